// File: rtl/pmp_cmd_rx.sv
// pmp_cmd_rx: receives PIC->FPGA command frames over the PMP bus and updates capture config.
// Optional feature macro: PMP_CSUM_EN (5-byte checksummed frame); default is a 4-byte frame.
module pmp_cmd_rx #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [15:0] DECIM_RST      = 16'h0010,
  parameter logic [15:0] PRETRIG_RST    = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pmp_d_in,
  input  logic        pmp_wrn,
  input  logic        pmp_enb,
  output logic [15:0] cfg_decim,
  output logic [7:0]  cfg_trig_level,
  output logic        cfg_trig_en,
  output logic        cfg_trig_rising,
  output logic [15:0] cfg_pretrig,
  output logic        rearm_pulse,
  output logic        cmd_done,
  output logic        err_csum,
  output logic        err_addr,
  output logic [7:0]  err_count,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DLO, S_DHI, S_CSUM} state_t;
  state_t        r_state;
  logic          r_wrn_s1, r_wrn_s2, r_wrn_s3, r_enb_s1, r_enb_s2, r_stb;
  logic [7:0]    r_d_s1, r_d_s2, r_byte, r_addr, r_dlo;
  logic [TW-1:0] r_tmo;
  logic          w_fin, w_ok, w_known, w_tmo, w_err;
  logic [7:0]    w_hi;
  logic [15:0]   w_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_wrn_s1, r_wrn_s2, r_wrn_s3} <= 3'b111;
      {r_enb_s1, r_enb_s2} <= 2'b00;
      r_d_s1 <= '0;
      r_d_s2 <= '0;
      r_stb <= 1'b0;
      r_byte <= '0;
    end else begin
      r_wrn_s1 <= pmp_wrn;
      r_wrn_s2 <= r_wrn_s1;
      r_wrn_s3 <= r_wrn_s2;
      r_enb_s1 <= pmp_enb;
      r_enb_s2 <= r_enb_s1;
      r_d_s1 <= pmp_d_in;
      r_d_s2 <= r_d_s1;
      r_stb <= r_wrn_s2 & ~r_wrn_s3 & r_enb_s2;
      r_byte <= r_d_s2;
    end
  end
`ifdef PMP_CSUM_EN
  logic [7:0] r_dhi;
  assign w_fin = r_stb && r_state == S_CSUM;
  assign w_ok  = r_byte == (r_addr ^ r_dlo ^ r_dhi);
  assign w_hi  = r_dhi;
`else
  assign w_fin    = r_stb && r_state == S_DHI;
  assign w_ok     = 1'b1;
  assign w_hi     = r_byte;
  assign err_csum = 1'b0;
`endif
  assign w_data  = {w_hi, r_dlo};
  assign w_known = r_addr < 8'd4;
  // a strobe landing on the expiry cycle keeps the frame alive
  assign w_tmo   = r_state != S_HUNT && !r_stb && r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign w_err   = w_tmo || (w_fin && !(w_ok && w_known));
  assign busy    = r_state != S_HUNT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
      r_tmo <= '0;
      r_addr <= '0;
      r_dlo <= '0;
`ifdef PMP_CSUM_EN
      r_dhi <= '0;
      err_csum <= 1'b0;
`endif
      cfg_decim <= DECIM_RST;
      cfg_trig_level <= 8'h80;
      cfg_trig_en <= 1'b0;
      cfg_trig_rising <= 1'b1;
      cfg_pretrig <= PRETRIG_RST;
      rearm_pulse <= 1'b0;
      cmd_done <= 1'b0;
      err_addr <= 1'b0;
      err_count <= '0;
    end else begin
`ifdef PMP_CSUM_EN
      err_csum <= w_fin && !w_ok;
`endif
      cmd_done <= w_fin && w_ok && w_known;
      err_addr <= w_fin && w_ok && !w_known;
      rearm_pulse <= w_fin && w_ok && r_addr == 8'h02 && r_dlo[2];
      err_count <= (w_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
      r_tmo <= (r_state == S_HUNT || r_stb || w_tmo) ? '0 : r_tmo + 1'b1;
      if (w_tmo)
        r_state <= S_HUNT;
      else if (r_stb)
        case (r_state)
          S_HUNT: r_state <= (r_byte == 8'hA5) ? S_ADDR : S_HUNT;
          S_ADDR: begin r_addr <= r_byte; r_state <= S_DLO; end
          S_DLO:  begin r_dlo <= r_byte; r_state <= S_DHI; end
`ifdef PMP_CSUM_EN
          S_DHI:  begin r_dhi <= r_byte; r_state <= S_CSUM; end
`endif
          default: r_state <= S_HUNT;
        endcase
      if (w_fin && w_ok)
        case (r_addr)
          8'h00: cfg_decim <= (w_data == 16'd0) ? 16'd1 : w_data;
          8'h01: cfg_trig_level <= r_dlo;
          8'h02: begin cfg_trig_en <= r_dlo[0]; cfg_trig_rising <= r_dlo[1]; end
          8'h03: cfg_pretrig <= w_data;
          default: ;
        endcase
    end
  end
endmodule
